// File: rtl/sram_line_controller.sv
// Bridges cache line fills (4 halfword reads) and write-through words (2 halfword
// writes) onto a 16-bit asynchronous SRAM with a fixed per-beat access time.
//
// state | meaning
// IDLE  | waiting for a request; rd_req has priority over wr_req
// READ  | four halfword beats filling line_data
// WRITE | two halfword beats, low half first
// DONE  | one cycle; line_valid pulses here after a read, busy released
module sram_line_controller #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        line_valid,
  output logic [63:0] line_data,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [2:0] CYC_LAST = 3'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  cyc;
  logic [1:0]  beat;
  logic [16:0] req_addr;
  logic [15:0] wdata_hi;
  logic        beat_end;
  logic        unused_addr;

  assign beat_end    = (cyc == CYC_LAST);
  assign unused_addr = ^{address[31:19], address[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cyc         <= '0;
      beat        <= '0;
      req_addr    <= '0;
      wdata_hi    <= '0;
      line_data   <= '0;
      line_valid  <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else begin
      state      <= state_nxt;
      line_valid <= (state == READ) && beat_end && (beat == 2'd3);
      case (state)
        IDLE: begin
          if (rd_req) begin
            req_addr  <= address[18:2];
            sram_addr <= {address[18:3], 2'b00};
          end else if (wr_req) begin
            req_addr    <= address[18:2];
            wdata_hi    <= wr_data[31:16];
            sram_addr   <= {address[18:2], 1'b0};
            sram_dq_out <= wr_data[15:0];
          end
        end
        READ: begin
          if (beat_end) begin
            line_data[{beat, 4'b0000} +: 16] <= sram_dq_in;
            cyc <= '0;
            if (beat == 2'd3) begin
              beat <= '0;
            end else begin
              beat      <= beat + 2'd1;
              sram_addr <= {req_addr[16:1], beat + 2'd1};
            end
          end else begin
            cyc <= cyc + 3'd1;
          end
        end
        WRITE: begin
          if (beat_end) begin
            cyc <= '0;
            if (beat == 2'd1) begin
              beat <= '0;
            end else begin
              beat        <= 2'd1;
              sram_addr   <= {req_addr, 1'b1};
              sram_dq_out <= wdata_hi;
            end
          end else begin
            cyc <= cyc + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (state)
      IDLE: begin
        busy = rd_req | wr_req;
        if (rd_req)      state_nxt = READ;
        else if (wr_req) state_nxt = WRITE;
      end
      READ: begin
        busy = 1'b1;
        if (beat_end && beat == 2'd3) state_nxt = DONE;
      end
      WRITE: begin
        busy       = 1'b1;
        sram_dq_oe = 1'b1;
        // the final cycle of a multi-cycle beat raises we_n to give address/data hold
        sram_we_n  = (ACCESS_CYCLES != 1) && beat_end;
        if (beat_end && beat == 2'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) busy = 1'b0;
  end

endmodule

// File: tb/tb_sram_line_controller.sv
// Self-checking bench: two controller instances (ACCESS_CYCLES 2 and 1), each on a
// behavioural SRAM, checked against a transaction-level memory model.
module tb_sram_line_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd_req, wr_req, sel, init_mem;
  logic [31:0] address, wr_data;

  logic        busy0, lv0, oe0, we0, busy1, lv1, oe1, we1;
  logic [63:0] ld0, ld1;
  logic [17:0] sa0, sa1;
  logic [15:0] dqo0, dqo1, dqi0, dqi1;
  logic        rd0, wr0, rd1, wr1;

  assign rd0 = rd_req & ~sel;
  assign wr0 = wr_req & ~sel;
  assign rd1 = rd_req & sel;
  assign wr1 = wr_req & sel;

  sram_line_controller #(.ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .rd_req(rd0), .wr_req(wr0), .address(address), .wr_data(wr_data),
    .busy(busy0), .line_valid(lv0), .line_data(ld0), .sram_addr(sa0), .sram_dq_out(dqo0),
    .sram_dq_in(dqi0), .sram_dq_oe(oe0), .sram_we_n(we0));

  sram_line_controller #(.ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .rd_req(rd1), .wr_req(wr1), .address(address), .wr_data(wr_data),
    .busy(busy1), .line_valid(lv1), .line_data(ld1), .sram_addr(sa1), .sram_dq_out(dqo1),
    .sram_dq_in(dqi1), .sram_dq_oe(oe1), .sram_we_n(we1));

  logic        busy_s, lv_s, oe_s, we_s;
  logic [63:0] ld_s;
  logic [17:0] sa_s;
  logic [15:0] dqo_s;
  assign busy_s = sel ? busy1 : busy0;
  assign lv_s   = sel ? lv1   : lv0;
  assign oe_s   = sel ? oe1   : oe0;
  assign we_s   = sel ? we1   : we0;
  assign ld_s   = sel ? ld1   : ld0;
  assign sa_s   = sel ? sa1   : sa0;
  assign dqo_s  = sel ? dqo1  : dqo0;

  function automatic logic [15:0] init_val(input int i);
    if (i >= 'h94 && i <= 'h97) return 16'(16'h1111 * (i - 'h93));
    return {8'(i), ~8'(i)};
  endfunction

  // behavioural SRAMs, 256 halfwords each (aliased on sram_addr[7:0])
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  assign dqi0 = mem0[sa0[7:0]];
  assign dqi1 = mem1[sa1[7:0]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= init_val(i);
        mem1[i] <= init_val(i);
      end
    end else begin
      if (oe0 && !we0) mem0[sa0[7:0]] <= dqo0;
      if (oe1 && !we1) mem1[sa1[7:0]] <= dqo1;
    end
  end

  logic [15:0] ref_mem [256];
  logic [63:0] last_line;
  logic [17:0] last_addr;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_line(input logic [17:0] base);
    logic [63:0] l;
    for (int k = 0; k < 4; k++)
      l[16*k +: 16] = sel ? init_val(int'(base[7:0]) + k) : ref_mem[8'(base[7:0] + 8'(k))];
    return l;
  endfunction

  // Starts in the current (idle) cycle, ends in the DONE cycle.
  task automatic run_op(input bit is_rd, input bit hold_wr, input logic [31:0] a,
                        input logic [31:0] wd, input int pulse_at, output logic [17:0] first_addr);
    int ac = sel ? 1 : 2;
    int n  = is_rd ? 4 * ac : 2 * ac;
    int k, cy;
    logic [17:0] base;
    logic [63:0] exp_line;
    base = is_rd ? (18'(a[18:0] >> 1) & ~18'd3) : (18'(a[18:0] >> 1) & ~18'd1);
    exp_line = model_line(base);
    rd_req = is_rd; wr_req = !is_rd || hold_wr; address = a; wr_data = wd;
    #1 chk("busy_accept", busy_s, 1);
    first_addr = '0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        wr_req = hold_wr; address = $urandom; wr_data = $urandom;
      end
      rd_req = (c == pulse_at);
      #1;
      k = (c - 1) / ac; cy = (c - 1) % ac;
      if (c == 1) first_addr = sa_s;
      chk($sformatf("sram_addr c%0d", c), sa_s, base + 18'(k));
      chk($sformatf("busy c%0d", c), busy_s, 1);
      chk($sformatf("line_valid c%0d", c), lv_s, 0);
      chk($sformatf("dq_oe c%0d", c), oe_s, !is_rd);
      chk($sformatf("we_n c%0d", c), we_s, is_rd || (ac > 1 && cy == ac - 1));
      if (!is_rd) chk($sformatf("dq_out c%0d", c), dqo_s, k ? wd[31:16] : wd[15:0]);
    end
    @(posedge clk); #1; rd_req = 0; #1;
    chk("done_line_valid", lv_s, is_rd);
    chk("done_busy", busy_s, 0);
    chk("done_we_n", we_s, 1);
    chk("done_oe", oe_s, 0);
    chk("done_addr_hold", sa_s, base + 18'(n / ac - 1));
    last_addr = base + 18'(n / ac - 1);
    if (is_rd) begin
      chk("done_line_data", ld_s, exp_line);
      last_line = exp_line;
    end else if (!sel) begin
      ref_mem[base[7:0]]       = wd[15:0];
      ref_mem[base[7:0] | 8'd1] = wd[31:16];
    end
  endtask

  task automatic idle_check();
    @(posedge clk); #2;
    chk("idle_busy", busy_s, 0);
    chk("idle_line_valid", lv_s, 0);
    chk("idle_we_n", we_s, 1);
    chk("idle_oe", oe_s, 0);
    chk("idle_addr_hold", sa_s, last_addr);
    chk("idle_line_stable", ld_s, last_line);
  endtask

  typedef struct {
    bit          is_rd;
    bit          hold_wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          pulse_at;
    logic [17:0] exp_first;
    logic [63:0] exp_line;
  } vec_t;

  vec_t vecs[4];
  logic [17:0] fa;

  initial begin
    vecs[0] = '{1, 0, 32'h0000_0128, 32'h0,         0, 18'h94, 64'h4444_3333_2222_1111};
    vecs[1] = '{0, 0, 32'h0000_0104, 32'hDEAD_BEEF, 0, 18'h82, 64'h0};
    vecs[2] = '{0, 0, 32'h0000_0208, 32'h1234_5678, 2, 18'h104, 64'h0};
    vecs[3] = '{1, 1, 32'h0000_0100, 32'hCAFE_F00D, 0, 18'h80, 64'hDEAD_BEEF_817E_807F};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    sel = 0; rst = 1; init_mem = 1; rd_req = 1; wr_req = 0; address = '0; wr_data = '0;
    last_line = '0; last_addr = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("busy_in_reset", busy_s, 0);
    @(posedge clk); #1; rst = 0; init_mem = 0; rd_req = 0; #1;
    chk("rst_line_data", ld_s, 0);
    chk("rst_sram_addr", sa_s, 0);
    chk("rst_dq_out", dqo_s, 0);
    chk("rst_line_valid", lv_s, 0);
    chk("rst_we_n", we_s, 1);
    chk("rst_oe", oe_s, 0);

    for (int v = 0; v < 4; v++) begin
      run_op(vecs[v].is_rd, vecs[v].hold_wr, vecs[v].a, vecs[v].wd, vecs[v].pulse_at, fa);
      chk($sformatf("vec%0d_first_addr", v), fa, vecs[v].exp_first);
      if (vecs[v].is_rd) chk($sformatf("vec%0d_line", v), ld_s, vecs[v].exp_line);
      if (vecs[v].hold_wr) begin
        @(posedge clk); #2;
        run_op(0, 0, vecs[v].a, vecs[v].wd, 0, fa);
        chk($sformatf("vec%0d_held_write_addr", v), fa, vecs[v].exp_first);
      end
      idle_check();
    end

    // reset at the start of read beat 2
    rd_req = 1; address = 32'h0000_0A00;
    @(posedge clk); #1; rd_req = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1; rst = 0; #1;
    last_line = '0; last_addr = '0;
    chk("abort_busy", busy_s, 0);
    chk("abort_line_data", ld_s, 0);
    chk("abort_sram_addr", sa_s, 0);
    chk("abort_we_n", we_s, 1);
    chk("abort_line_valid", lv_s, 0);
    repeat (8) idle_check();

    // single-cycle beats
    sel = 1; last_line = '0; last_addr = '0;
    run_op(1, 0, 32'h0003_0040, 32'h0, 0, fa);
    chk("ac1_first_addr", fa, 18'h18020);
    idle_check();
    run_op(0, 0, 32'h0003_0050, 32'h0BAD_F00D, 0, fa);
    idle_check();

    sel = 0; last_line = '0; last_addr = '0;
    for (int r = 0; r < 40; r++) begin
      bit rdop;
      rdop = 1'($urandom);
      run_op(rdop, 0, $urandom, $urandom, rdop ? 0 : int'($urandom_range(0, 4)), fa);
      repeat (1 + $urandom_range(0, 2)) idle_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_line_controller.md
SRAM_LINE_CONTROLLER -- requirements
Module: sram_line_controller

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2, clock cycles per SRAM halfword access (legal 1..7).
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have rd_req  input  1  cache line-fill request (cache miss).
REQ-005 SHALL have wr_req  input  1  write-through word request.
REQ-006 SHALL have address  input  32  byte address of the request.
REQ-007 SHALL have wr_data  input  32  word to write.
REQ-008 SHALL have busy  output  1  freeze to cache/pipeline (drives pause_SRAM).
REQ-009 SHALL have line_valid  output  1  one-cycle pulse, line_data holds a complete 64-bit line (drives readyFlagData64B).
REQ-010 SHALL have line_data  output  64  fetched line, halfword k in bits [16k+15:16k].
REQ-011 SHALL have sram_addr  output  18  SRAM halfword address.
REQ-012 SHALL have sram_dq_out  output  16  write data to SRAM.
REQ-013 SHALL have sram_dq_in  input  16  read data from SRAM.
REQ-014 SHALL have sram_dq_oe  output  1  1 = controller drives data bus.
REQ-015 SHALL have sram_we_n  output  1  SRAM write enable, active-low.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-017 IDLE: rd_req=1 SHALL latch address and go to READ; else wr_req=1 SHALL latch address/wr_data and go to WRITE; rd_req wins if both high.
REQ-018 Requests in READ, WRITE or DONE SHALL be ignored (no queueing); requester holds request until accepted.
REQ-019 READ SHALL perform 4 halfword beats k=0..3 at sram_addr = {latched address[18:3], k[1:0]}.
REQ-020 WRITE SHALL perform 2 beats at sram_addr = {latched address[18:2], k[0]}, beat 0 wr_data[15:0], beat 1 wr_data[31:16].
REQ-021 Each beat SHALL last exactly ACCESS_CYCLES cycles; a 3-bit cycle counter and 2-bit beat counter SHALL sequence beats, both cleared at beat/operation end.
REQ-022 READ SHALL sample sram_dq_in into line_data halfword k on the last cycle of beat k.
REQ-023 WRITE SHALL hold sram_dq_oe=1, sram_dq_out stable, sram_we_n=0 for all cycles of each beat except the last, where sram_we_n=1 (address/data hold).
REQ-024 READ SHALL keep sram_we_n=1, sram_dq_oe=0.
REQ-025 After last beat, FSM SHALL enter DONE for exactly 1 cycle, then IDLE.
REQ-026 line_valid SHALL be 1 only in DONE following READ; 0 after WRITE.
REQ-027 line_data SHALL remain stable from DONE until next READ beat 0 sample.
REQ-028 busy SHALL equal (state is READ or WRITE) OR (state is IDLE AND (rd_req OR wr_req)), combinational, 0 while rst=1.
REQ-029 busy SHALL be 0 in DONE so the cache captures the line that cycle.
REQ-030 Latency: read accept edge to line_valid = 4*ACCESS_CYCLES+1 cycles; write accept to DONE = 2*ACCESS_CYCLES+1 cycles.
REQ-031 In IDLE/DONE sram_addr SHALL hold last value, sram_we_n=1, sram_dq_oe=0.
REQ-032 ACCESS_CYCLES=1: single-cycle beats; write beat SHALL then assert sram_we_n=0 for its whole cycle.

Reset
REQ-033 On rst=1 at clock edge: state=IDLE, counters=0, line_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, line_valid=0.
REQ-034 Reset mid-READ or mid-WRITE SHALL abort immediately, discard partial line, produce no line_valid.

Verification
REQ-035 Read, ACCESS_CYCLES=2, address=0x0000_0128, SRAM returns 0x1111,0x2222,0x3333,0x4444 -> sram_addr 0x94..0x97, line_valid on cycle 9, line_data=0x4444_3333_2222_1111.
REQ-036 Write address=0x0000_0104, wr_data=0xDEAD_BEEF -> sram_addr 0x82 data 0xBEEF, then 0x83 data 0xDEAD, we_n low 1 cycle per beat, no line_valid, busy low at DONE (cycle 5).
REQ-037 rd_req and wr_req together in IDLE -> READ taken; wr_req held -> WRITE starts after DONE+IDLE.
REQ-038 rst asserted at beat 2 of read -> next cycle IDLE, we_n=1, line_data=0, no line_valid pulse.
REQ-039 ACCESS_CYCLES=1 read -> line_valid 5 cycles after accept, busy high 4 cycles after accept cycle.
REQ-040 rd_req pulsed during WRITE -> ignored; busy stays high; no READ unless rd_req still high in IDLE.
